// File: rtl/vga_sync_monitor.sv
// Measures VGA sync timing (line/frame period and pulse widths) and reports a stable mode.
// Optional macro VGA_SYNC_MONITOR_POL_AUTO_EN enables automatic sync polarity detection.
module vga_sync_monitor #(
    parameter int HCNT_W  = 12,
    parameter int VCNT_W  = 11,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [HCNT_W-1:0] h_total,
    output logic [HCNT_W-1:0] h_pulse,
    output logic [VCNT_W-1:0] v_total,
    output logic [VCNT_W-1:0] v_pulse,
    output logic              hsync_pol,
    output logic              vsync_pol,
    output logic              locked,
    output logic              mode_stb,
    output logic              no_signal
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v, input logic en);
        logic [HCNT_W-1:0] r;
        if (en && (v != {HCNT_W{1'b1}})) begin
            r = v + HCNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [VCNT_W-1:0] sat_inc_v(input logic [VCNT_W-1:0] v, input logic en);
        logic [VCNT_W-1:0] r;
        if (en && (v != {VCNT_W{1'b1}})) begin
            r = v + VCNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]        hs_sync_r, vs_sync_r;
    logic              hs_prev_r, vs_prev_r;
    logic              h_act_s, h_act_prev_s, v_act_s, v_act_prev_s;
    logic              h_lead_s, h_trail_s, v_lead_s, v_trail_s;
    logic [HCNT_W-1:0] hcnt_r, h_cur_s;
    logic [VCNT_W-1:0] vcnt_r, v_inc_s;
    logic [TO_W-1:0]   tcnt_r;
    logic              timeout_s;
    logic              pol_chg_s;
    state_t            state_r;
    logic [HCNT_W-1:0] ref_h_r;
    logic [VCNT_W-1:0] ref_v_r;
    logic              ref_valid_r;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            hs_sync_r <= 2'b00;
            vs_sync_r <= 2'b00;
            hs_prev_r <= 1'b0;
            vs_prev_r <= 1'b0;
        end else begin
            hs_sync_r <= {hs_sync_r[0], hsync_in};
            vs_sync_r <= {vs_sync_r[0], vsync_in};
            hs_prev_r <= hs_sync_r[1];
            vs_prev_r <= vs_sync_r[1];
        end
    end

    // Active level is the synchronized value XNOR polarity (pol=0 means active-low)
    assign h_act_s      = hs_sync_r[1] ~^ hsync_pol;
    assign h_act_prev_s = hs_prev_r ~^ hsync_pol;
    assign v_act_s      = vs_sync_r[1] ~^ vsync_pol;
    assign v_act_prev_s = vs_prev_r ~^ vsync_pol;
    assign h_lead_s     = h_act_s & ~h_act_prev_s;
    assign h_trail_s    = ~h_act_s & h_act_prev_s;
    assign v_lead_s     = v_act_s & ~v_act_prev_s;
    assign v_trail_s    = ~v_act_s & v_act_prev_s;

    // A coincident hsync edge belongs to the frame that is closing
    assign v_inc_s   = sat_inc_v(vcnt_r, h_lead_s);
    assign h_cur_s   = h_lead_s ? hcnt_r : h_total;
    assign timeout_s = ~h_lead_s & (tcnt_r >= TO_LAST);

    // Horizontal counter with line period and pulse width latches
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            hcnt_r  <= '0;
            h_total <= '0;
            h_pulse <= '0;
        end else begin
            if (h_lead_s) begin
                h_total <= hcnt_r;
                hcnt_r  <= HCNT_W'(1);
            end else begin
                hcnt_r  <= sat_inc_h(hcnt_r, 1'b1);
            end
            if (h_trail_s) begin
                h_pulse <= hcnt_r;
            end
        end
    end

    // Line counter with frame height, vsync width and mode strobe
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            vcnt_r   <= '0;
            v_total  <= '0;
            v_pulse  <= '0;
            mode_stb <= 1'b0;
        end else begin
            if (v_lead_s) begin
                v_total  <= v_inc_s;
                vcnt_r   <= '0;
                mode_stb <= 1'b1;
            end else begin
                vcnt_r   <= v_inc_s;
                mode_stb <= 1'b0;
            end
            if (v_trail_s) begin
                v_pulse <= v_inc_s;
            end
        end
    end

    // Loss-of-signal watchdog restarted by every hsync leading edge
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            tcnt_r    <= '0;
            no_signal <= 1'b1;
        end else if (h_lead_s) begin
            tcnt_r    <= '0;
            no_signal <= 1'b0;
        end else if (tcnt_r >= TO_LAST) begin
            no_signal <= 1'b1;
        end else begin
            tcnt_r    <= tcnt_r + TO_W'(1);
        end
    end

`ifdef VGA_SYNC_MONITOR_POL_AUTO_EN
    logic [HCNT_W-1:0] h_hi_r, h_lo_r;
    logic [VCNT_W-1:0] v_hi_r, v_lo_r;
    logic              h_primed_r, v_primed_r;
    logic              h_rise_s, v_rise_s, h_new_s, v_new_s;

    // Each signal's period is delimited by its raw rising edge, independent of polarity
    assign h_rise_s  = hs_sync_r[1] & ~hs_prev_r;
    assign v_rise_s  = vs_sync_r[1] & ~vs_prev_r;
    assign h_new_s   = (h_hi_r < h_lo_r);
    assign v_new_s   = (v_hi_r < v_lo_r);
    assign pol_chg_s = (h_rise_s & h_primed_r & (h_new_s != hsync_pol)) |
                       (v_rise_s & v_primed_r & (v_new_s != vsync_pol));

    // High/low time accumulators; the first period after reset is partial and only primes them
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            h_hi_r     <= '0;
            h_lo_r     <= '0;
            v_hi_r     <= '0;
            v_lo_r     <= '0;
            h_primed_r <= 1'b0;
            v_primed_r <= 1'b0;
            hsync_pol  <= 1'b0;
            vsync_pol  <= 1'b0;
        end else begin
            if (h_rise_s) begin
                if (h_primed_r) begin
                    hsync_pol <= h_new_s;
                end
                h_primed_r <= 1'b1;
                h_hi_r     <= HCNT_W'(1);
                h_lo_r     <= '0;
            end else if (hs_sync_r[1]) begin
                h_hi_r <= sat_inc_h(h_hi_r, 1'b1);
            end else begin
                h_lo_r <= sat_inc_h(h_lo_r, 1'b1);
            end
            if (v_rise_s) begin
                if (v_primed_r) begin
                    vsync_pol <= v_new_s;
                end
                v_primed_r <= 1'b1;
                v_hi_r     <= '0;
                v_lo_r     <= '0;
            end else if (vs_sync_r[1]) begin
                v_hi_r <= sat_inc_v(v_hi_r, h_lead_s);
            end else begin
                v_lo_r <= sat_inc_v(v_lo_r, h_lead_s);
            end
        end
    end
`else
    assign hsync_pol = 1'b0;
    assign vsync_pol = 1'b0;
    assign pol_chg_s = 1'b0;
`endif

    // Mode tracking: lock after two consecutive frames with identical geometry
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            locked      <= 1'b0;
            ref_h_r     <= '0;
            ref_v_r     <= '0;
            ref_valid_r <= 1'b0;
        end else if (timeout_s) begin
            state_r     <= IDLE;
            locked      <= 1'b0;
            ref_valid_r <= 1'b0;
        end else if (pol_chg_s && (state_r != IDLE)) begin
            state_r     <= MEASURE;
            locked      <= 1'b0;
            ref_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    locked <= 1'b0;
                    if (h_lead_s) begin
                        state_r     <= MEASURE;
                        ref_valid_r <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (v_lead_s) begin
                        if (ref_valid_r && (h_cur_s == ref_h_r) && (v_inc_s == ref_v_r)) begin
                            state_r <= LOCKED;
                            locked  <= 1'b1;
                        end
                        ref_h_r     <= h_cur_s;
                        ref_v_r     <= v_inc_s;
                        ref_valid_r <= 1'b1;
                    end else if (h_lead_s && (hcnt_r != ref_h_r)) begin
                        ref_valid_r <= 1'b0;
                    end
                end
                LOCKED: begin
                    if ((h_lead_s && (hcnt_r != ref_h_r)) || (v_lead_s && (v_inc_s != ref_v_r))) begin
                        state_r     <= MEASURE;
                        locked      <= 1'b0;
                        ref_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    locked      <= 1'b0;
                    ref_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using short 5-line frames (2 vsync lines) to bound run time.
module tb_vga_sync_monitor;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] h_total, h_pulse;
    logic [10:0] v_total, v_pulse;
    logic        hsync_pol, vsync_pol, locked, mode_stb, no_signal;

    int checks = 0;
    int errors = 0;
    bit stb_seen = 1'b0;
    bit stb_locked = 1'b0;

    vga_sync_monitor dut (
        .clk_vga   (clk_vga),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .h_total   (h_total),
        .h_pulse   (h_pulse),
        .v_total   (v_total),
        .v_pulse   (v_pulse),
        .hsync_pol (hsync_pol),
        .vsync_pol (vsync_pol),
        .locked    (locked),
        .mode_stb  (mode_stb),
        .no_signal (no_signal)
    );

    always #5 clk_vga = ~clk_vga;

    always @(negedge clk_vga) begin
        if (mode_stb && !stb_seen) begin
            stb_seen   = 1'b1;
            stb_locked = locked;
        end
    end

    task automatic drive_cycles(input logic hs, input logic vs, input int n);
        hsync_in = hs;
        vsync_in = vs;
        repeat (n) @(posedge clk_vga);
        #1;
    endtask

    task automatic drive_line(input int period, input logic vs, input logic pol);
        drive_cycles(pol, vs, 108);
        drive_cycles(~pol, vs, period - 108);
    endtask

    task automatic drive_frame(input int period, input logic pol);
        for (int l = 0; l < 5; l++) begin
            drive_line(period, (l < 2) ? pol : ~pol, pol);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(posedge clk_vga);
        #1;
        checks++; if (h_total !== 12'd0) begin errors++; $display("FAIL reset_h_total: got %0d want 0", h_total); end
        checks++; if (h_pulse !== 12'd0) begin errors++; $display("FAIL reset_h_pulse: got %0d want 0", h_pulse); end
        checks++; if (v_total !== 11'd0 || v_pulse !== 11'd0) begin errors++; $display("FAIL reset_v: got %0d/%0d want 0/0", v_total, v_pulse); end
        checks++; if (hsync_pol !== 1'b0 || vsync_pol !== 1'b0) begin errors++; $display("FAIL reset_pol: got %0b%0b want 00", hsync_pol, vsync_pol); end
        checks++; if (locked !== 1'b0 || mode_stb !== 1'b0) begin errors++; $display("FAIL reset_lock_stb: got %0b%0b want 00", locked, mode_stb); end
        checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL reset_no_signal: got %0b want 1", no_signal); end
        rst = 1'b0;
        drive_cycles(1'b1, 1'b1, 20);
    endtask

    task automatic test_lock;
        drive_frame(900, 1'b0);
        drive_frame(900, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %0b want 0", locked); end
        drive_frame(900, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_after_frames: got %0b want 1", locked); end
        checks++; if (h_total !== 12'd900) begin errors++; $display("FAIL lock_h_total: got %0d want 900", h_total); end
        checks++; if (h_pulse !== 12'd108) begin errors++; $display("FAIL lock_h_pulse: got %0d want 108", h_pulse); end
        checks++; if (v_total !== 11'd5) begin errors++; $display("FAIL lock_v_total: got %0d want 5", v_total); end
        checks++; if (v_pulse !== 11'd2) begin errors++; $display("FAIL lock_v_pulse: got %0d want 2", v_pulse); end
        checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL lock_no_signal: got %0b want 0", no_signal); end
`ifndef VGA_SYNC_MONITOR_POL_AUTO_EN
        checks++; if (hsync_pol !== 1'b0 || vsync_pol !== 1'b0) begin errors++; $display("FAIL fixed_pol: got %0b%0b want 00", hsync_pol, vsync_pol); end
`endif
    endtask

    task automatic test_line_change;
        drive_line(800, 1'b0, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL change_first_line: got %0b want 1", locked); end
        drive_cycles(1'b0, 1'b0, 5);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL change_unlock: got %0b want 0", locked); end
        drive_cycles(1'b0, 1'b0, 103);
        drive_cycles(1'b1, 1'b0, 692);
        for (int l = 2; l < 5; l++) begin
            drive_line(800, (l < 2) ? 1'b0 : 1'b1, 1'b0);
        end
        drive_frame(800, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL change_relock_early: got %0b want 0", locked); end
        drive_frame(800, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL change_relock: got %0b want 1", locked); end
        checks++; if (h_total !== 12'd800) begin errors++; $display("FAIL change_h_total: got %0d want 800", h_total); end
    endtask

    task automatic test_timeout;
        drive_line(900, 1'b0, 1'b0);
        hsync_in = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk_vga);
            #1;
            if (i == 3196) begin
                checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b want 0", no_signal); end
            end
            if (i == 3197) begin
                checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL timeout_edge: got %0b want 1", no_signal); end
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %0b want 0", locked); end
        checks++; if (h_total !== 12'd800 || h_pulse !== 12'd108) begin errors++; $display("FAIL timeout_retain: got %0d/%0d want 800/108", h_total, h_pulse); end
        drive_frame(900, 1'b0);
        checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL resume_no_signal: got %0b want 0", no_signal); end
        checks++; if (h_total !== 12'd900) begin errors++; $display("FAIL resume_h_total: got %0d want 900", h_total); end
    endtask

    task automatic test_saturation;
        drive_line(5000, 1'b1, 1'b0);
        drive_line(5000, 1'b1, 1'b0);
        checks++; if (h_total !== 12'd4095) begin errors++; $display("FAIL sat_h_total: got %0d want 4095", h_total); end
        checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL sat_no_signal: got %0b want 1", no_signal); end
    endtask

    task automatic test_mid_reset;
        drive_line(900, 1'b0, 1'b0);
        drive_cycles(1'b0, 1'b0, 50);
        rst = 1'b1;
        #2;
        checks++; if (h_total !== 12'd0 || h_pulse !== 12'd0) begin errors++; $display("FAIL async_reset_h: got %0d/%0d want 0/0", h_total, h_pulse); end
        checks++; if (v_total !== 11'd0 || v_pulse !== 11'd0) begin errors++; $display("FAIL async_reset_v: got %0d/%0d want 0/0", v_total, v_pulse); end
        checks++; if (no_signal !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got ns=%0b lk=%0b want 1/0", no_signal, locked); end
        repeat (3) @(posedge clk_vga);
        #1;
        rst = 1'b0;
        drive_cycles(1'b1, 1'b1, 20);
        stb_seen = 1'b0;
        drive_frame(900, 1'b0);
        checks++; if (stb_seen !== 1'b1) begin errors++; $display("FAIL restart_stb_seen: got %0b want 1", stb_seen); end
        checks++; if (stb_locked !== 1'b0) begin errors++; $display("FAIL restart_stb_locked: got %0b want 0", stb_locked); end
        drive_frame(900, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL restart_second_frame: got %0b want 0", locked); end
        drive_frame(900, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL restart_relock: got %0b want 1", locked); end
    endtask

`ifdef VGA_SYNC_MONITOR_POL_AUTO_EN
    task automatic test_polarity;
        rst = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (3) @(posedge clk_vga);
        #1;
        rst = 1'b0;
        drive_cycles(1'b0, 1'b0, 20);
        for (int f = 0; f < 4; f++) begin
            drive_frame(900, 1'b1);
        end
        checks++; if (hsync_pol !== 1'b1 || vsync_pol !== 1'b1) begin errors++; $display("FAIL auto_pol: got %0b%0b want 11", hsync_pol, vsync_pol); end
        checks++; if (h_pulse !== 12'd108) begin errors++; $display("FAIL auto_pol_h_pulse: got %0d want 108", h_pulse); end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_line_change();
        test_timeout();
        test_saturation();
        test_mid_reset();
`ifdef VGA_SYNC_MONITOR_POL_AUTO_EN
        test_polarity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
